// File: rtl/atri_event_fifo_param.sv
// atri_event_fifo_param: single-clock {type,data} event FIFO with word/event counts and programmable-empty flag.
// Define ATRI_EVFIFO_DROP_EN to drop whole events on overflow; otherwise overflowing words are discarded singly.
module atri_event_fifo_param #(
  parameter int DATA_WIDTH  = 16,
  parameter int TYPE_WIDTH  = 2,
  parameter int DEPTH_LOG2  = 13,
  parameter int PE_THRESH   = 4,
  parameter int EVCNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fifo_rst_i,
  input  logic                   fifo_wr_i,
  input  logic [DATA_WIDTH-1:0]  dat_i,
  input  logic [TYPE_WIDTH-1:0]  type_i,
  output logic                   fifo_full_o,
  input  logic                   fifo_rd_i,
  output logic [DATA_WIDTH-1:0]  dat_o,
  output logic [TYPE_WIDTH-1:0]  type_o,
  output logic                   fifo_empty_o,
  output logic                   prog_empty_o,
  output logic [DEPTH_LOG2:0]    fifo_nwords_o,
  output logic [EVCNT_WIDTH-1:0] nevents_o,
  output logic                   overflow_o
);
  localparam int W = TYPE_WIDTH + DATA_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;
  logic [W-1:0] mem [DEPTH];
  ptr_t wr_ptr, rd_ptr, wr_next, rd_next, commit_next, used_next, words_next;
  logic wr_acc, rd_acc, ev_inc, ev_dec, last_in;
  logic [EVCNT_WIDTH-1:0] nevents_next;
  logic [W-1:0] rd_word;
  assign last_in = type_i[TYPE_WIDTH-1];
  assign rd_word = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign rd_acc = fifo_rd_i & ~fifo_empty_o & ~fifo_rst_i;
  assign rd_next = fifo_rst_i ? '0 : rd_ptr + ptr_t'(rd_acc);
`ifdef ATRI_EVFIFO_DROP_EN
  typedef enum logic {IDLE, DROP} state_t;
  state_t state, state_next;
  ptr_t commit;
  // Readers only see words up to commit; an overflowing event is rolled back and its tail skipped.
  always_comb begin
    state_next = state;
    wr_acc = 1'b0;
    wr_next = wr_ptr;
    commit_next = commit;
    if (fifo_rst_i) begin
      state_next = IDLE;
      wr_next = '0;
      commit_next = '0;
    end else if (fifo_wr_i) begin
      if (state == DROP || fifo_full_o) begin
        state_next = last_in ? IDLE : DROP;
        wr_next = commit;
      end else begin
        wr_acc = 1'b1;
        wr_next = wr_ptr + ptr_t'(1);
        if (last_in) commit_next = wr_ptr + ptr_t'(1);
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      commit <= '0;
    end else begin
      state <= state_next;
      commit <= commit_next;
    end
`else
  assign wr_acc = fifo_wr_i & ~fifo_full_o & ~fifo_rst_i;
  assign wr_next = fifo_rst_i ? '0 : wr_ptr + ptr_t'(wr_acc);
  assign commit_next = wr_next;
`endif
  assign used_next = wr_next - rd_next;
  assign words_next = commit_next - rd_next;
  assign ev_inc = wr_acc & last_in;
  assign ev_dec = rd_acc & rd_word[W-1];
  assign nevents_next = fifo_rst_i ? '0 :
    (ev_inc && !ev_dec && nevents_o != '1) ? nevents_o + EVCNT_WIDTH'(1) :
    (ev_dec && !ev_inc && nevents_o != '0) ? nevents_o - EVCNT_WIDTH'(1) : nevents_o;
  always_ff @(posedge clk_i)
    if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {type_i, dat_i};
  // Flags are registered from next-state pointers so they always agree with fifo_nwords_o.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_nwords_o <= '0;
      fifo_full_o <= 1'b0;
      fifo_empty_o <= 1'b1;
      prog_empty_o <= 1'b1;
      nevents_o <= '0;
      overflow_o <= 1'b0;
      {type_o, dat_o} <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      fifo_nwords_o <= words_next;
      fifo_full_o <= used_next == ptr_t'(DEPTH);
      fifo_empty_o <= words_next == '0;
      prog_empty_o <= int'(words_next) <= PE_THRESH;
      nevents_o <= nevents_next;
      overflow_o <= ~fifo_rst_i & (overflow_o | (fifo_wr_i & fifo_full_o));
      {type_o, dat_o} <= fifo_rst_i ? '0 : rd_acc ? rd_word : {type_o, dat_o};
    end
endmodule
